nanov_spi_ram_responder: RTL and testbench

//  SPI RAM responder: the memory-device end of the nanoV SPI instruction/data bus.

---
 rtl/nanov_spi_ram_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_nanov_spi_ram_responder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanov_spi_ram_responder.sv
// SPI RAM responder: memory-device end of the nanoV SPI bus (0x03 READ / 0x02 WRITE, 24-bit address, streaming).
// Latency: first read bit on spi_miso the cycle after the last address bit slot (zero dummy cycles).
// Backpressure: none; the master paces every bit with spi_clk_enable, and a stall of any length holds all state.
//
// Ports:
//   clk, rstn             system clock, synchronous active-low reset
//   spi_select            chip select, active low; deselect returns to IDLE from any state
//   spi_clk_enable        bit strobe; a bit slot is a posedge with spi_select=0 and spi_clk_enable=1
//   spi_mosi / spi_miso   serial data in / registered serial data out, MSB first
//   load_valid/addr/data  preload write into the backing array, honoured only while idle and deselected
//   busy                  high whenever the FSM is not in IDLE
//   cmd_error             one-cycle pulse on unsupported command or rejected high address bits

module nanov_spi_ram_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int ERR_ON_HIGH = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_select,
  input  logic                 spi_clk_enable,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  input  logic                 load_valid,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 busy,
  output logic                 cmd_error
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    READ   = 3'd3,
    WRITE  = 3'd4,
    IGNORE = 3'd5
  } state_t;

  // Backing array: never reset, so contents survive both rstn and deselect.
  logic [7:0] mem [DEPTH];

  state_t               state, state_n;
  logic [4:0]           bit_cnt, bit_cnt_n;
  logic [6:0]           cmd_sr, cmd_sr_n;     // first 7 command bits; the 8th comes straight from spi_mosi
  logic [22:0]          addr_sr, addr_sr_n;   // first 23 address bits; the 24th comes straight from spi_mosi
  logic [ADDR_BITS-1:0] addr, addr_n;
  logic                 is_wr, is_wr_n;
  logic [6:0]           out_sr, out_sr_n;     // remaining bits of the read byte; bit 7 lives in spi_miso
  logic [6:0]           in_sr, in_sr_n;
  logic                 miso_n;
  logic                 err_n;

  logic                 slot;
  logic [23:0]          full_addr;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [7:0]           rd_data;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_wa;
  logic [7:0]           mem_wd;

  assign slot      = !spi_select && spi_clk_enable;
  assign full_addr = {addr_sr, spi_mosi};

  // Single combinational read port: during ADDR it looks up the address being completed,
  // otherwise it pre-fetches the next sequential byte so reloads happen with no gap.
  always_comb begin
    rd_addr = addr + ADDR_ONE;
    if (state == ADDR) begin
      rd_addr = full_addr[ADDR_BITS-1:0];
    end
  end

  assign rd_data = mem[rd_addr];

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    cmd_sr_n  = cmd_sr;
    addr_sr_n = addr_sr;
    addr_n    = addr;
    is_wr_n   = is_wr;
    out_sr_n  = out_sr;
    in_sr_n   = in_sr;
    miso_n    = spi_miso;
    err_n     = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = addr;
    mem_wd    = {in_sr, spi_mosi};

    if (spi_select) begin
      // Deselect wins over everything; a partially shifted write byte is simply dropped.
      state_n   = IDLE;
      bit_cnt_n = 5'd0;
      miso_n    = 1'b0;
      if (state == IDLE && load_valid) begin
        mem_we = 1'b1;
        mem_wa = load_addr;
        mem_wd = load_data;
      end
    end else begin
      case (state)
        IDLE: begin
          // The select edge itself may already carry the first command bit.
          state_n   = CMD;
          bit_cnt_n = 5'd0;
          miso_n    = 1'b0;
          if (slot) begin
            cmd_sr_n  = {cmd_sr[5:0], spi_mosi};
            bit_cnt_n = 5'd1;
          end
        end

        CMD: begin
          if (slot) begin
            cmd_sr_n = {cmd_sr[5:0], spi_mosi};
            if (bit_cnt == 5'd7) begin
              bit_cnt_n = 5'd0;
              case ({cmd_sr, spi_mosi})
                8'h03: begin
                  state_n = ADDR;
                  is_wr_n = 1'b0;
                end
                8'h02: begin
                  state_n = ADDR;
                  is_wr_n = 1'b1;
                end
                default: begin
                  state_n = IGNORE;
                  err_n   = 1'b1;
                end
              endcase
            end else begin
              bit_cnt_n = bit_cnt + 5'd1;
            end
          end
        end

        ADDR: begin
          if (slot) begin
            addr_sr_n = {addr_sr[21:0], spi_mosi};
            if (bit_cnt == 5'd23) begin
              bit_cnt_n = 5'd0;
              if (ERR_ON_HIGH != 0 && |full_addr[23:ADDR_BITS]) begin
                state_n = IGNORE;
                err_n   = 1'b1;
              end else begin
                addr_n = full_addr[ADDR_BITS-1:0];
                if (is_wr) begin
                  state_n = WRITE;
                end else begin
                  // Present the MSB on the very next cycle: no dummy slots.
                  state_n  = READ;
                  miso_n   = rd_data[7];
                  out_sr_n = rd_data[6:0];
                end
              end
            end else begin
              bit_cnt_n = bit_cnt + 5'd1;
            end
          end
        end

        READ: begin
          if (slot) begin
            if (bit_cnt == 5'd7) begin
              bit_cnt_n = 5'd0;
              addr_n    = addr + ADDR_ONE;
              miso_n    = rd_data[7];
              out_sr_n  = rd_data[6:0];
            end else begin
              bit_cnt_n = bit_cnt + 5'd1;
              miso_n    = out_sr[6];
              out_sr_n  = {out_sr[5:0], 1'b0};
            end
          end
        end

        WRITE: begin
          if (slot) begin
            in_sr_n = {in_sr[5:0], spi_mosi};
            if (bit_cnt == 5'd7) begin
              bit_cnt_n = 5'd0;
              mem_we    = 1'b1;
              mem_wa    = addr;
              mem_wd    = {in_sr, spi_mosi};
              addr_n    = addr + ADDR_ONE;
            end else begin
              bit_cnt_n = bit_cnt + 5'd1;
            end
          end
        end

        IGNORE: begin
          miso_n = 1'b0;
        end

        default: begin
          state_n = IDLE;
          miso_n  = 1'b0;
        end
      endcase
    end

    if (!rstn) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      bit_cnt   <= 5'd0;
      cmd_sr    <= 7'd0;
      addr_sr   <= 23'd0;
      addr      <= '0;
      is_wr     <= 1'b0;
      out_sr    <= 7'd0;
      in_sr     <= 7'd0;
      spi_miso  <= 1'b0;
      cmd_error <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      cmd_sr    <= cmd_sr_n;
      addr_sr   <= addr_sr_n;
      addr      <= addr_n;
      is_wr     <= is_wr_n;
      out_sr    <= out_sr_n;
      in_sr     <= in_sr_n;
      spi_miso  <= miso_n;
      cmd_error <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_nanov_spi_ram_responder.sv
module tb_nanov_spi_ram_responder;

  logic       clk = 1'b0;
  logic       rstn;
  logic       spi_select;
  logic       spi_clk_enable;
  logic       spi_mosi;
  logic       spi_miso;
  logic       load_valid;
  logic [9:0] load_addr;
  logic [7:0] load_data;
  logic       busy;
  logic       cmd_error;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [1024];
  logic [7:0] exp_q [$];

  nanov_spi_ram_responder #(.ADDR_BITS(10), .ERR_ON_HIGH(0)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .spi_select     (spi_select),
    .spi_clk_enable (spi_clk_enable),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .load_valid     (load_valid),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .busy           (busy),
    .cmd_error      (cmd_error)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task stall(input int n);
    logic held;
    for (int k = 0; k < n; k++) begin
      held = spi_miso;
      tick;
      checks++;
      if (spi_miso !== held) begin
        errors++;
        $display("FAIL stall_hold: miso %b required %b", spi_miso, held);
      end
    end
  endtask

  // One bit slot; m is the miso value the master sees on that edge.
  task slot(input logic b, output logic m);
    m = spi_miso;
    spi_mosi = b;
    spi_clk_enable = 1'b1;
    tick;
    spi_clk_enable = 1'b0;
    spi_mosi = 1'b0;
  endtask

  task send_bits(input logic [23:0] v, input int n, input int stall_at);
    logic m;
    for (int i = n - 1; i >= 0; i--) begin
      slot(v[i], m);
      if (i == stall_at) stall(5);
    end
  endtask

  task start_cmd(input logic [7:0] cmd, input logic [23:0] a, input int addr_stall);
    spi_select = 1'b0;
    send_bits({16'h0000, cmd}, 8, -1);
    send_bits(a, 24, addr_stall);
  endtask

  task deselect;
    spi_select = 1'b1;
    spi_mosi = 1'b0;
    tick;
  endtask

  task preload(input logic [9:0] a, input logic [7:0] d);
    load_valid = 1'b1;
    load_addr = a;
    load_data = d;
    tick;
    load_valid = 1'b0;
    model[a] = d;
  endtask

  task expect_mem(input logic [9:0] a, input int n);
    logic [9:0] p;
    for (int k = 0; k < n; k++) begin
      p = a + 10'(k);
      exp_q.push_back(model[p]);
    end
  endtask

  task write_bytes(input logic [9:0] a, input logic [7:0] d [4], input int n);
    logic [9:0] p;
    start_cmd(8'h02, {14'h0, a}, -1);
    for (int k = 0; k < n; k++) begin
      send_bits({16'h0000, d[k]}, 8, -1);
      p = a + 10'(k);
      model[p] = d[k];
    end
  endtask

  task read_expect(input int nbytes, input int data_stall_bit, input string name);
    logic m;
    logic [7:0] got;
    logic [7:0] e;
    for (int b = 0; b < nbytes; b++) begin
      for (int i = 7; i >= 0; i--) begin
        slot(1'b0, m);
        got[i] = m;
        if (b == 0 && i == data_stall_bit) stall(5);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: byte %0d got %h with nothing expected", name, b, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL %s: byte %0d got %h required %h", name, b, got, e);
        end
      end
    end
  endtask

  task test_reset;
    rstn = 1'b0;
    spi_select = 1'b1;
    spi_clk_enable = 1'b0;
    spi_mosi = 1'b0;
    load_valid = 1'b0;
    load_addr = '0;
    load_data = '0;
    tick;
    tick;
    checks++;
    if (busy !== 1'b0 || spi_miso !== 1'b0 || cmd_error !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy %b miso %b cmd_error %b required 0 0 0", busy, spi_miso, cmd_error);
    end
    rstn = 1'b1;
    tick;
  endtask

  task test_read_basic;
    logic m;
    logic [7:0] first;
    preload(10'h000, 8'h13);
    preload(10'h001, 8'h00);
    preload(10'h002, 8'h00);
    preload(10'h003, 8'h00);
    start_cmd(8'h03, 24'h000000, -1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL read_busy: busy %b required 1", busy);
    end
    // Spec-literal first byte, independent of the model.
    for (int i = 7; i >= 0; i--) begin
      slot(1'b0, m);
      first[i] = m;
    end
    checks++;
    if (first !== 8'b00010011) begin
      errors++;
      $display("FAIL read_first_byte: got %b required 00010011", first);
    end
    expect_mem(10'h001, 3);
    read_expect(3, -1, "read_basic");
    deselect;
  endtask

  task test_write_read;
    logic [7:0] d [4];
    d = '{8'hA5, 8'h3C, 8'h00, 8'h00};
    write_bytes(10'h010, d, 2);
    deselect;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL write_busy_after_deselect: busy %b required 0", busy);
    end
    start_cmd(8'h03, 24'h000010, -1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    read_expect(2, -1, "write_read");
    deselect;
  endtask

  task test_wrap;
    preload(10'h3FF, 8'h5A);
    preload(10'h000, 8'hC3);
    start_cmd(8'h03, 24'h0003FF, -1);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    read_expect(2, -1, "wrap");
    deselect;
  endtask

  task test_stall;
    preload(10'h000, 8'h13);
    start_cmd(8'h03, 24'h000000, 10);
    expect_mem(10'h000, 4);
    read_expect(4, 3, "stall_stream");
    deselect;
  endtask

  task test_partial_write;
    preload(10'h020, 8'h77);
    start_cmd(8'h02, 24'h000020, -1);
    send_bits(24'h00001F, 5, -1);
    deselect;
    start_cmd(8'h03, 24'h000020, -1);
    exp_q.push_back(8'h77);
    read_expect(1, -1, "partial_write");
    deselect;
  endtask

  task test_bad_cmd;
    logic m;
    logic any_one;
    spi_select = 1'b0;
    send_bits(24'h000005, 8, -1);
    checks++;
    if (cmd_error !== 1'b1) begin
      errors++;
      $display("FAIL bad_cmd_pulse: cmd_error %b required 1", cmd_error);
    end
    tick;
    checks++;
    if (cmd_error !== 1'b0) begin
      errors++;
      $display("FAIL bad_cmd_pulse_width: cmd_error %b required 0", cmd_error);
    end
    any_one = 1'b0;
    for (int i = 0; i < 12; i++) begin
      slot(1'b1, m);
      if (m !== 1'b0) any_one = 1'b1;
    end
    checks++;
    if (any_one !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bad_cmd_ignore: miso_seen_high %b busy %b required 0 1", any_one, busy);
    end
    deselect;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_cmd_busy_release: busy %b required 0", busy);
    end
  endtask

  task test_preload_blocked;
    preload(10'h030, 8'h11);
    spi_select = 1'b0;
    load_valid = 1'b1;
    load_addr = 10'h030;
    load_data = 8'hEE;
    tick;
    tick;
    load_valid = 1'b0;
    deselect;
    start_cmd(8'h03, 24'h000030, -1);
    exp_q.push_back(8'h11);
    read_expect(1, -1, "preload_blocked");
    deselect;
  endtask

  task test_reset_mid_read;
    start_cmd(8'h03, 24'h000010, -1);
    checks++;
    if (spi_miso !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_read_pre: miso %b required 1", spi_miso);
    end
    rstn = 1'b0;
    tick;
    checks++;
    if (spi_miso !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: miso %b busy %b required 0 0", spi_miso, busy);
    end
    spi_select = 1'b1;
    rstn = 1'b1;
    tick;
    start_cmd(8'h03, 24'h000010, -1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    read_expect(2, -1, "reset_contents");
    deselect;
  endtask

  task test_back_to_back;
    logic [7:0] d [4];
    for (int k = 0; k < 4; k++) d[k] = 8'($urandom_range(0, 255));
    write_bytes(10'h3FE, d, 4);
    deselect;
    start_cmd(8'h03, 24'h0003FE, -1);
    expect_mem(10'h3FE, 4);
    read_expect(4, -1, "back_to_back");
    deselect;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_read_basic;
    test_write_read;
    test_wrap;
    test_stall;
    test_partial_write;
    test_bad_cmd;
    test_preload_blocked;
    test_reset_mid_read;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
